// File: rtl/vedic_mul8_seq_ctrl.sv
// rtl/vedic_mul8_seq_ctrl.sv - sequences one shared HALFxHALF Vedic core over 4 cycles into a WIDTHxWIDTH product
module vedic_mul8_seq_ctrl #(
    parameter int WIDTH = 8,
    localparam int HALF = WIDTH / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [HALF-1:0]      core_a,
    output logic [HALF-1:0]      core_b,
    input  logic [WIDTH-1:0]     core_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [1:0]           step;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic [2*WIDTH-1:0]   p_ext;
    logic [2*WIDTH-1:0]   addend;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign out_p     = acc;
    assign p_ext     = {{WIDTH{1'b0}}, core_p};

    // Core operands are forced to zero outside MUL so the shared core stays quiet.
    always_comb begin
        core_a = '0;
        core_b = '0;
        if (state == S_MUL) begin
            case (step)
                2'd0: begin core_a = opa[HALF-1:0];     core_b = opb[HALF-1:0];     end
                2'd1: begin core_a = opa[HALF-1:0];     core_b = opb[WIDTH-1:HALF]; end
                2'd2: begin core_a = opa[WIDTH-1:HALF]; core_b = opb[HALF-1:0];     end
                default: begin core_a = opa[WIDTH-1:HALF]; core_b = opb[WIDTH-1:HALF]; end
            endcase
        end
    end

    always_comb begin
        addend = p_ext;
        case (step)
            2'd0:    addend = p_ext;
            2'd1:    addend = p_ext << HALF;
            2'd2:    addend = p_ext << HALF;
            default: addend = p_ext << WIDTH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            step  <= 2'd0;
            acc   <= '0;
            opa   <= '0;
            opb   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        opa   <= in_a;
                        opb   <= in_b;
                        acc   <= '0;
                        step  <= 2'd0;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc  <= acc + addend;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_mul8_seq_ctrl.sv
// tb/tb_vedic_mul8_seq_ctrl.sv - self-checking bench for vedic_mul8_seq_ctrl
module tb_vedic_mul8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [3:0]  core_a;
    logic [3:0]  core_b;
    logic [7:0]  core_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        busy;

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit chk_en  = 1'b0;

    vedic_mul8_seq_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .core_a(core_a), .core_b(core_b), .core_p(core_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
    );

    // Stand-in for the combinational Vedic core.
    assign core_p = {4'b0, core_a} * {4'b0, core_b};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an op is accepted when idle, result is a*b, ready 4 edges later.
    bit        m_busy = 1'b0;
    int        m_cnt  = 0;
    logic [7:0] m_a, m_b;
    logic [15:0] m_prod;
    int        m_accepts = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_a    = in_a;
                m_b    = in_b;
                m_prod = 16'(in_a) * 16'(in_b);
                m_accepts++;
            end
        end else if (m_cnt < 4) begin
            m_cnt++;
        end else if (out_ready) begin
            m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] ea, eb;
            ea = 4'd0;
            eb = 4'd0;
            if (m_busy && m_cnt < 4) begin
                ea = (m_cnt < 2) ? m_a[3:0] : m_a[7:4];
                eb = (m_cnt == 0 || m_cnt == 2) ? m_b[3:0] : m_b[7:4];
            end
            check("in_ready", in_ready, !m_busy);
            check("busy", busy, m_busy);
            check("out_valid", out_valid, m_busy && m_cnt == 4);
            check("core_a", core_a, ea);
            check("core_b", core_b, eb);
            if (m_busy && m_cnt == 4) check("out_p", out_p, m_prod);
        end
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] lit, input int stall);
        int lat;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = a ^ b;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 4);
        check("lit_out_p", out_p, lit);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1'b1);
            check("stall_out_p", out_p, lit);
            check("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("after_handoff_valid", out_valid, 1'b0);
        out_ready = 1'b0;
    endtask

    initial begin
        int acc_at[$];
        int guard;
        rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; out_ready = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_p", out_p, 16'h0000);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;

        do_op(8'h12, 8'h34, 16'h03A8, 0);
        do_op(8'hFF, 8'hFF, 16'hFE01, 0);
        do_op(8'h00, 8'hA7, 16'h0000, 0);
        do_op(8'hA5, 8'h5A, 16'h3A02, 10);

        // in_valid held high with fresh operands every cycle
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1;
        in_a = 8'($urandom); in_b = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) acc_at.push_back(i);
            @(posedge clk); #1;
            in_a = 8'($urandom); in_b = 8'($urandom);
        end
        in_valid = 1'b0;
        check("b2b_accepts", acc_at.size(), 4);
        for (int i = 1; i < acc_at.size(); i++) check("b2b_spacing", acc_at[i] - acc_at[i-1], 6);
        guard = 0;
        while (busy && guard < 20) begin @(posedge clk); #1; guard++; end
        check("b2b_drained", busy, 1'b0);
        out_ready = 1'b0;

        // reset while the core is on step2
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_core_a", core_a, 4'h1);
        check("pre_rst_core_b", core_b, 4'h4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_core_a", core_a, 4'h0);
        check("midrst_core_b", core_b, 4'h0);
        check("midrst_out_p", out_p, 16'h0000);
        do_op(8'h03, 8'h05, 16'h000F, 0);

        // random traffic with stalls, checked by the reference each cycle
        guard = 0;
        m_accepts = 0;
        while (m_accepts < 1000 && guard < 30000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(3) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            out_ready = $urandom_range(1);
            guard++;
        end
        check("random_done", m_accepts >= 1000, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
